// File: rtl/multi_chan_delay_pkg.sv
// ---------------------------------------------------------------------------
// multi_chan_delay_pkg
// Shared constants and types for the multi-channel delay line.
//   DEF_*      : default values for the top-level parameters
//   MAX_WIDTH  : widest channel the stage struct can carry
//   stage_t    : one pipeline stage of one channel (valid + data)
//   fault_reachable() : true when the fault compare value fits in the counter
// ---------------------------------------------------------------------------
package multi_chan_delay_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 2;
    localparam int DEF_CTR_W       = 11;
    localparam int DEF_FAULT_CYCLE = 40;

    // Stage data is sized for the widest legal channel; narrower channels
    // keep their sample in the low bits and leave the rest at zero.
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 vld;
        logic [MAX_WIDTH-1:0] data;
    } stage_t;

    // A compare value the counter can never hold must never fire, so it has
    // to be rejected before truncation to the counter width.
    function automatic bit fault_reachable(input int fault_cycle, input int ctr_w);
        return (fault_cycle >= 0) && (longint'(fault_cycle) < (longint'(1) << ctr_w));
    endfunction

endpackage

// File: rtl/delay_chan.sv
// ---------------------------------------------------------------------------
// delay_chan
// One channel of the delay line: DEPTH register stages, the last of which is
// the output register. Stages advance when en is high; flush clears every
// valid bit (data untouched) and wins over en. hold keeps the output data
// register at its old value for one advance while everything else shifts.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en, flush, hold : advance, clear valids, suppress output data update
//   din, din_vld    : channel input sample and its valid
//   dout, dout_vld  : sample and valid delayed by DEPTH enabled cycles
// ---------------------------------------------------------------------------
module delay_chan
    import multi_chan_delay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld
);

    stage_t               stage_q [DEPTH];
    stage_t               stage_d [DEPTH];
    logic [MAX_WIDTH-1:0] unused_tail;

    // Next-state of the stage chain. A held output still lets every earlier
    // stage move on, so the suppressed sample is simply dropped.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s];
        end
        if (flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_d[s].vld = 1'b0;
            end
        end else if (en) begin
            stage_d[0].vld  = din_vld;
            stage_d[0].data = MAX_WIDTH'(din);
            for (int s = 1; s < DEPTH; s++) begin
                stage_d[s] = stage_q[s-1];
            end
            if (hold) begin
                stage_d[DEPTH-1].data = stage_q[DEPTH-1].data;
            end
        end
    end

    // Stage registers, cleared asynchronously so in-flight samples vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign dout        = stage_q[DEPTH-1].data[WIDTH-1:0];
    assign dout_vld    = stage_q[DEPTH-1].vld;
    // Upper data bits of the output stage are always zero padding.
    assign unused_tail = stage_q[DEPTH-1].data;

endmodule

// File: rtl/multi_chan_delay.sv
// ---------------------------------------------------------------------------
// multi_chan_delay
// N_CH independent fixed-latency delay lines sharing enable/flush, plus a
// free-running cycle counter. With macro MULTI_CHAN_DELAY_FAULT_EN defined,
// an advance taken while the counter equals FAULT_CYCLE freezes the output
// data of every channel selected by fault_mask and pulses fault_hit on the
// following cycle; without it fault_mask is ignored and fault_hit is 0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   en, flush        : pipeline advance, clear all valids
//   din, din_vld     : per-channel data (channel c at [c*WIDTH +: WIDTH]), valid
//   fault_mask       : channels affected by fault injection
//   dout, dout_vld   : delayed data (same packing) and valid
//   cycle_ctr        : free-running cycle count, wraps
//   fault_hit        : one-cycle pulse after a fault event
// ---------------------------------------------------------------------------
module multi_chan_delay
    import multi_chan_delay_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CTR_W       = DEF_CTR_W,
    parameter int FAULT_CYCLE = DEF_FAULT_CYCLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic [N_CH*WIDTH-1:0] din,
    input  logic [N_CH-1:0]       din_vld,
    input  logic [N_CH-1:0]       fault_mask,
    output logic [N_CH*WIDTH-1:0] dout,
    output logic [N_CH-1:0]       dout_vld,
    output logic [CTR_W-1:0]      cycle_ctr,
    output logic                  fault_hit
);

    logic [CTR_W-1:0] ctr_q;
    logic [N_CH-1:0]  hold;

    // The counter ignores en and flush so fault timing is tied to wall time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_q + CTR_W'(1);
        end
    end

    assign cycle_ctr = ctr_q;

`ifdef MULTI_CHAN_DELAY_FAULT_EN
    localparam bit FAULT_REACHABLE = fault_reachable(FAULT_CYCLE, CTR_W);

    logic fault_event;
    logic fault_hit_q;

    // Only a real advance at the trigger count counts as a fault event.
    assign fault_event = FAULT_REACHABLE && en && !flush &&
                         (ctr_q == CTR_W'(FAULT_CYCLE));
    assign hold        = fault_event ? fault_mask : '0;

    // Registered so the pulse lines up with the frozen output sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_hit_q <= 1'b0;
        end else begin
            fault_hit_q <= fault_event;
        end
    end

    assign fault_hit = fault_hit_q;
`else
    logic [N_CH-1:0] unused_fault_mask;

    assign unused_fault_mask = fault_mask;
    assign hold              = '0;
    assign fault_hit         = 1'b0;
`endif

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_chan
            delay_chan #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .flush    (flush),
                .hold     (hold[c]),
                .din      (din[c*WIDTH +: WIDTH]),
                .din_vld  (din_vld[c]),
                .dout     (dout[c*WIDTH +: WIDTH]),
                .dout_vld (dout_vld[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_chan_delay.sv
// ---------------------------------------------------------------------------
// tb_multi_chan_delay
// Directed bench for multi_chan_delay. The main instance uses the defaults;
// two small-counter instances (CTR_W=4) watch fault recurrence and the
// unreachable-trigger case. Expected fault behaviour follows whether
// MULTI_CHAN_DELAY_FAULT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_multi_chan_delay;

`ifdef MULTI_CHAN_DELAY_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [31:0] din;
    logic [3:0]  din_vld;
    logic [3:0]  fault_mask;

    logic [31:0] dout;
    logic [3:0]  dout_vld;
    logic [10:0] cycle_ctr;
    logic        fault_hit;

    logic [31:0] s_dout;
    logic [3:0]  s_vld;
    logic [3:0]  s_ctr;
    logic        s_hit;

    logic [31:0] n_dout;
    logic [3:0]  n_vld;
    logic [3:0]  n_ctr;
    logic        n_hit;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    multi_chan_delay u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .din_vld    (din_vld),
        .fault_mask (fault_mask),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .cycle_ctr  (cycle_ctr),
        .fault_hit  (fault_hit)
    );

    multi_chan_delay #(.CTR_W(4), .FAULT_CYCLE(3)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .din_vld    (din_vld),
        .fault_mask (fault_mask),
        .dout       (s_dout),
        .dout_vld   (s_vld),
        .cycle_ctr  (s_ctr),
        .fault_hit  (s_hit)
    );

    multi_chan_delay #(.CTR_W(4), .FAULT_CYCLE(16)) u_never (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .din_vld    (din_vld),
        .fault_mask (fault_mask),
        .dout       (n_dout),
        .dout_vld   (n_vld),
        .cycle_ctr  (n_ctr),
        .fault_hit  (n_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel c carries v + 64*c so each lane is distinguishable.
    function automatic logic [31:0] ramp(input int v);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) begin
            r[c*8 +: 8] = 8'(v + 64 * c);
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic e, input logic f,
                                 input logic [31:0] d, input logic [3:0] v);
        en      = e;
        flush   = f;
        din     = d;
        din_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkMain(input string tag, input logic [31:0] exp_dout,
                             input logic [3:0] exp_vld, input int exp_ctr,
                             input logic exp_hit);
        checkOutput({tag, ".dout"},      64'(dout),      64'(exp_dout));
        checkOutput({tag, ".dout_vld"},  64'(dout_vld),  64'(exp_vld));
        checkOutput({tag, ".cycle_ctr"}, 64'(cycle_ctr), 64'(exp_ctr));
        checkOutput({tag, ".fault_hit"}, 64'(fault_hit), 64'(exp_hit));
    endtask

    // Ramp from a fresh reset: edge e carries value e-1, so dout shows e-2.
    task automatic runRamp(input string tag, input int n);
        logic [31:0] exp_d;
        int          val;
        for (int e = 1; e <= n; e++) begin
            applyStimulus(1'b1, 1'b0, ramp(e - 1), 4'hF);
            for (int c = 0; c < 4; c++) begin
                val = e - 2;
                if (FAULT_ON && e == 41 && c == 1) val = e - 3;
                exp_d[c*8 +: 8] = 8'(val + 64 * c);
            end
            if (e == 1) exp_d = '0;
            checkMain($sformatf("%s[%0d]", tag, e), exp_d,
                      (e >= 2) ? 4'hF : 4'h0, e, FAULT_ON && e == 41);
            checkOutput($sformatf("%s[%0d].small_ctr", tag, e),
                        64'(s_ctr), 64'(e % 16));
            checkOutput($sformatf("%s[%0d].small_hit", tag, e),
                        64'(s_hit), 64'(FAULT_ON && (e % 16) == 4));
            checkOutput($sformatf("%s[%0d].never_hit", tag, e),
                        64'(n_hit), 64'(0));
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        en         = 1'b0;
        flush      = 1'b0;
        din        = '0;
        din_vld    = '0;
        fault_mask = 4'b0010;

        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkMain("reset", 32'h0, 4'h0, 0, 1'b0);
        rst_n = 1'b1;

        runRamp("ramp_a", 20);

        // Asynchronous reset mid-stream, held across three edges.
        rst_n = 1'b0;
        #1;
        checkMain("rst_async", 32'h0, 4'h0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkMain("rst_hold", 32'h0, 4'h0, 0, 1'b0);
        end
        rst_n = 1'b1;

        runRamp("ramp_b", 45);

        // Stall: outputs frozen while garbage sits on the inputs.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 32'hEEEE_EEEE, 4'h0);
            checkMain("en_low", ramp(43), 4'hF, 46 + k, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, ramp(45 + k), 4'hF);
            checkMain("resume", ramp(44 + k), 4'hF, 51 + k, 1'b0);
        end

        // Flush clears valids only; with en high nothing shifts either.
        applyStimulus(1'b0, 1'b1, 32'h9999_9999, 4'hF);
        checkMain("flush_en0", ramp(46), 4'h0, 54, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h9999_9999, 4'hF);
        checkMain("flush_en1", ramp(46), 4'h0, 55, 1'b0);
        applyStimulus(1'b1, 1'b0, ramp(48), 4'hF);
        checkMain("refill1", ramp(47), 4'h0, 56, 1'b0);
        applyStimulus(1'b1, 1'b0, ramp(49), 4'hF);
        checkMain("refill2", ramp(48), 4'hF, 57, 1'b0);

        // Per-channel valids travel independently.
        applyStimulus(1'b1, 1'b0, ramp(50), 4'b0101);
        checkMain("vld_mix1", ramp(49), 4'hF, 58, 1'b0);
        applyStimulus(1'b1, 1'b0, ramp(51), 4'hF);
        checkMain("vld_mix2", ramp(50), 4'b0101, 59, 1'b0);
        applyStimulus(1'b1, 1'b0, ramp(52), 4'hF);
        checkMain("vld_mix3", ramp(51), 4'hF, 60, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/multi_chan_delay.md
MULTI_CHAN_DELAY -- requirements
Module: multi_chan_delay

Interface
REQ-001 The block SHALL take parameter N_CH, default 4, number of independent channels (1..16).
REQ-002 The block SHALL take parameter WIDTH, default 8, data bits per channel (1..64).
REQ-003 The block SHALL take parameter DEPTH, default 2, pipeline latency in cycles (1..32).
REQ-004 The block SHALL take parameter CTR_W, default 11, cycle-counter width.
REQ-005 The block SHALL take parameter FAULT_CYCLE, default 40, counter value at which a fault is injected.
REQ-006 The block SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-007 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port en  input  1  pipeline advance enable.
REQ-009 The block SHALL have port flush  input  1  clears all valid bits.
REQ-010 The block SHALL have port din  input  N_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-011 The block SHALL have port din_vld  input  N_CH  per-channel input valid.
REQ-012 The block SHALL have port fault_mask  input  N_CH  channels subject to fault injection.
REQ-013 The block SHALL have port dout  output  N_CH*WIDTH  delayed data, same packing as din.
REQ-014 The block SHALL have port dout_vld  output  N_CH  delayed valid.
REQ-015 The block SHALL have port cycle_ctr  output  CTR_W  free-running cycle count.
REQ-016 The block SHALL have port fault_hit  output  1  one-cycle pulse on fault injection.

Function
REQ-017 cycle_ctr SHALL increment by 1 on every posedge clk irrespective of en and flush, wrapping from 2^CTR_W-1 to 0.
REQ-018 With en=1, each channel SHALL shift din/din_vld through DEPTH register stages, so dout/dout_vld equal the values sampled DEPTH enabled cycles earlier.
REQ-019 With en=0, all stage registers, dout and dout_vld SHALL hold.
REQ-020 flush=1 SHALL clear every stage valid and dout_vld on that edge regardless of en; data registers are unchanged; flush has priority over en.
REQ-021 A fault event SHALL occur on an edge where en=1, flush=0 and cycle_ctr (pre-increment) equals FAULT_CYCLE.
REQ-022 On a fault event, the dout data of each channel with fault_mask bit set SHALL retain its previous value while its dout_vld updates normally; unmasked channels update normally.
REQ-023 Internal stages SHALL always shift on a fault event; only the output register is suppressed, so the dropped sample is lost and subsequent samples are unaffected.
REQ-024 fault_hit SHALL be 1 for exactly the cycle following a fault event (registered), else 0, including when fault_mask is all-zero.
REQ-025 FAULT_CYCLE >= 2^CTR_W SHALL never produce a fault event.
REQ-026 The fault SHALL recur every 2^CTR_W cycles as the counter wraps.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear cycle_ctr, all stage data and valid, dout, dout_vld and fault_hit to 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; first dout_vld after release appears no earlier than DEPTH enabled cycles after the first valid input.

Configuration
REQ-029 Macro MULTI_CHAN_DELAY_FAULT_EN SHALL compile in REQ-021..REQ-026 logic.
REQ-030 Without MULTI_CHAN_DELAY_FAULT_EN, fault_mask SHALL be ignored, fault_hit SHALL be tied 0, and dout SHALL always equal the DEPTH-delayed input; cycle_ctr remains functional.

Structure
REQ-031 Package multi_chan_delay_pkg SHALL hold default constants (N_CH, WIDTH, DEPTH, CTR_W, FAULT_CYCLE) and the per-channel valid/data stage struct typedef.
REQ-032 One sub-module delay_chan SHALL implement a single channel (DEPTH stages plus output hold input), instantiated N_CH times by generate.

Verification
REQ-033 Defaults, en=1, din ch0 = cycle index, din_vld=4'hF -> dout ch0 equals index-2 at every cycle, dout_vld=4'hF from cycle 2.
REQ-034 fault_mask=4'b0010, ramp on all channels -> at counter 40 ch1 dout holds previous value one cycle, other channels exact; fault_hit=1 the following cycle only.
REQ-035 en=0 for 5 cycles mid-stream -> dout/dout_vld frozen; resume -> no sample lost or duplicated.
REQ-036 flush=1 with en=0 for one cycle -> dout_vld=0 next cycle; valid returns DEPTH cycles after new din_vld.
REQ-037 rst_n pulsed low for 3 cycles at cycle 20 -> all outputs 0 immediately; cycle_ctr restarts at 0, fault at new count 40.
REQ-038 CTR_W=4, FAULT_CYCLE=3 -> fault_hit pulses at cycles 4, 20, 36 (period 16); build without macro -> fault_hit never 1.
